// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the uart_tx scheduler slice: FSM encodings, UART state
// encodings used by uart_tx, and a constant ceil-log2 helper.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        UartIdle  = 2'd0,
        UartStart = 2'd1,
        UartData  = 2'd2,
        UartStop  = 2'd3
    } uart_state_e;

    // Minimum result of 1 so a width derived from it is never zero.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            v = v >> 1;
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester/transmitter bundle for uart_tx_sched. The master modport is the
// scheduler side; slave is the requesters plus the uart_tx done pulse.
interface uart_tx_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);
    import uart_tx_sched_pkg::*;

    localparam int unsigned IdxW = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_done;
    logic                      busy;
    logic [IdxW-1:0]           owner;
    logic                      timeout;

    modport master (
        input  req, req_data, tx_done,
        output grant, tx_data, tx_start, busy, owner, timeout
    );

    modport slave (
        output req, req_data, tx_done,
        input  grant, tx_data, tx_start, busy, owner, timeout
    );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req scanning upward from rr_ptr,
// wrapping modulo NUM_REQ.
module uart_tx_sched_rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IdxW-1:0]    winner_idx,
    output logic               any
);

    logic [IdxW-1:0] idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        idx        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IdxW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!any && req[idx]) begin
                winner[idx] = 1'b1;
                winner_idx  = idx;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte requesters:
// grant and latch a byte, pulse tx_start, then wait for tx_done or the watchdog.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input logic             clk,
    input logic             rst,
    uart_tx_sched_if.master bus
);

    localparam int unsigned IdxW  = clog2(NUM_REQ);
    localparam int unsigned WdogW = clog2(TIMEOUT) + 1;
    localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_REQ - 1);

    sched_state_e       state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic               timeout_q, timeout_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WdogW-1:0]   wdog_q, wdog_d;

    logic [NUM_REQ-1:0] win_onehot;
    logic [IdxW-1:0]    win_idx;
    logic               win_any;
    logic [DATA_W-1:0]  win_data;
    logic [IdxW-1:0]    next_ptr;

    uart_tx_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (bus.req),
        .rr_ptr     (rr_ptr_q),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .any        (win_any)
    );

    // AND-OR mux keyed by the one-hot winner.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_data = win_data | bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        owner_d    = owner_q;
        timeout_d  = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        wdog_d     = wdog_q;
        unique case (state_q)
            StIdle: begin
                if (win_any) begin
                    grant_d   = win_onehot;
                    tx_data_d = win_data;
                    owner_d   = win_idx;
                    busy_d    = 1'b1;
                    state_d   = StLaunch;
                end
            end
            StLaunch: begin
                tx_start_d = 1'b1;
                wdog_d     = '0;
                state_d    = StWait;
            end
            StWait: begin
                wdog_d = wdog_q + 1'b1;
                // tx_done takes priority over a coincident watchdog expiry.
                if (bus.tx_done) begin
                    rr_ptr_d = next_ptr;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end else if (wdog_q == WdogLast) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            timeout_q  <= 1'b0;
            rr_ptr_q   <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            timeout_q  <= timeout_d;
            rr_ptr_q   <= rr_ptr_d;
            wdog_q     <= wdog_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with NUM_REQ=4, DATA_W=8, TIMEOUT=16;
// uart_tx is modelled by driving tx_done by hand.
module tb_uart_tx_sched;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    uart_tx_sched_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    uart_tx_sched #(
        .NUM_REQ (4),
        .DATA_W  (8),
        .TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant on the first edge, tx_start on the second, tx_done after wait_cycles WAIT edges.
    task automatic run_frame(input string tag, input logic [3:0] req_v,
                             input logic [3:0] req_after, input logic [3:0] exp_grant,
                             input logic [1:0] exp_owner, input logic [7:0] exp_data,
                             input int wait_cycles);
        bus.req = req_v;
        tick();
        check({tag, ".grant"}, 32'(bus.grant), 32'(exp_grant));
        check({tag, ".owner"}, 32'(bus.owner), 32'(exp_owner));
        check({tag, ".data"}, 32'(bus.tx_data), 32'(exp_data));
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        check({tag, ".nostart"}, 32'(bus.tx_start), 32'd0);
        bus.req = req_after;
        tick();
        check({tag, ".start"}, 32'(bus.tx_start), 32'd1);
        check({tag, ".grant0"}, 32'(bus.grant), 32'd0);
        check({tag, ".data_held"}, 32'(bus.tx_data), 32'(exp_data));
        repeat (wait_cycles) tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check({tag, ".idle"}, 32'(bus.busy), 32'd0);
        check({tag, ".no_to"}, 32'(bus.timeout), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        vectors      = 0;
        miscompares  = 0;
        bus.req      = '0;
        bus.req_data = 32'h44A5_2211;
        bus.tx_done  = 1'b0;

        tick();
        tick();
        check("rst.grant", 32'(bus.grant), 32'd0);
        check("rst.data", 32'(bus.tx_data), 32'd0);
        check("rst.start", 32'(bus.tx_start), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.owner", 32'(bus.owner), 32'd0);
        check("rst.timeout", 32'(bus.timeout), 32'd0);
        rst = 1'b0;
        tick();
        check("idle.busy", 32'(bus.busy), 32'd0);

        // Single request from requester 2.
        run_frame("single", 4'b0100, 4'b0000, 4'b0100, 2'd2, 8'hA5, 2);
        check("single.data_kept", 32'(bus.tx_data), 32'hA5);

        // rr_ptr is 3: requester 3 first, then the pointer wraps to 0.
        run_frame("wrap3", 4'b1001, 4'b1001, 4'b1000, 2'd3, 8'h44, 1);
        run_frame("wrap0", 4'b1001, 4'b0000, 4'b0001, 2'd0, 8'h11, 1);

        // tx_done during LAUNCH is ignored.
        bus.req = 4'b0010;
        tick();
        check("coll.grant", 32'(bus.grant), 32'b0010);
        bus.req     = 4'b0000;
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("coll.start", 32'(bus.tx_start), 32'd1);
        check("coll.busy_launch", 32'(bus.busy), 32'd1);
        tick();
        check("coll.busy_wait", 32'(bus.busy), 32'd1);
        tick();
        check("coll.still_busy", 32'(bus.busy), 32'd1);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("coll.done", 32'(bus.busy), 32'd0);

        // Asynchronous reset while waiting on requester 3.
        bus.req = 4'b1000;
        tick();
        check("mid.grant", 32'(bus.grant), 32'b1000);
        bus.req = 4'b0000;
        tick();
        tick();
        check("mid.busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid.rst_busy", 32'(bus.busy), 32'd0);
        check("mid.rst_data", 32'(bus.tx_data), 32'd0);
        check("mid.rst_owner", 32'(bus.owner), 32'd0);
        check("mid.rst_start", 32'(bus.tx_start), 32'd0);
        rst = 1'b0;
        tick();

        // Round robin from rr_ptr=0 with all requesters held.
        bus.req_data = 32'h4433_2211;
        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("rr%0d", i), 4'b1111, 4'b1111, 4'(1 << (i % 4)),
                      2'(i % 4), 8'((i % 4 + 1) * 8'h11), 1);
        end
        bus.req = 4'b0000;
        tick();

        // Watchdog expiry: rr_ptr=1, requester 1 times out, requester 2 follows.
        bus.req = 4'b0110;
        tick();
        check("to.grant", 32'(bus.grant), 32'b0010);
        bus.req = 4'b0100;
        tick();
        check("to.start", 32'(bus.tx_start), 32'd1);
        repeat (15) tick();
        check("to.not_yet", 32'(bus.timeout), 32'd0);
        check("to.busy_pre", 32'(bus.busy), 32'd1);
        tick();
        check("to.pulse", 32'(bus.timeout), 32'd1);
        check("to.busy_drop", 32'(bus.busy), 32'd0);
        tick();
        check("to.pulse_end", 32'(bus.timeout), 32'd0);
        check("to.next_grant", 32'(bus.grant), 32'b0100);
        check("to.next_owner", 32'(bus.owner), 32'd2);
        check("to.next_data", 32'(bus.tx_data), 32'h33);
        bus.req = 4'b0000;
        tick();
        check("tie.start", 32'(bus.tx_start), 32'd1);
        // tx_done on the expiry cycle wins over the timeout.
        repeat (15) tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("tie.busy", 32'(bus.busy), 32'd0);
        check("tie.no_to", 32'(bus.timeout), 32'd0);
        tick();
        check("tie.no_to_late", 32'(bus.timeout), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
